pdm_cic_decimator: RTL and testbench
====================================

PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 128, decimation ratio; legal values 32, 64, 128, 256.
REQ-002 SHALL have port clk  input  1  single system clock (128x44.1 kHz at DECIM=128).
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clk_enable  input  1  qualifies every state advance; low = all internal state holds.
REQ-005 SHALL have port pdm_in  input  1  1-bit PDM bitstream, one bit per qualified clk.
REQ-006 SHALL have port output_data  output  16  signed two's-complement PCM sample.
REQ-007 SHALL have port ce_out  output  1  one-clk strobe marking a new output_data value.

Function
REQ-008 SHALL map pdm_in 1 -> +1 and 0 -> -1 as a 2-bit signed integrator input.
REQ-009 SHALL implement a 3rd-order CIC filter: 3 integrators at input rate, 3 combs (differential delay 1) at decimated rate.
REQ-010 SHALL size all integrator and comb registers to ACC_W = 2 + 3*log2(DECIM) bits (23 at DECIM=128).
REQ-011 SHALL let integrators wrap modulo 2^ACC_W with no saturation; wrap is required for correct CIC behaviour.
REQ-012 SHALL run a decimation counter 0..DECIM-1, advancing on each qualified cycle and wrapping DECIM-1 -> 0.
REQ-013 SHALL treat a qualified cycle with counter == DECIM-1 as a sample event, capturing the third integrator register into the comb chain.
REQ-014 SHALL register the comb chain result on the sample event's next qualified cycle, and scaled/saturated output_data plus ce_out on the qualified cycle after that.
REQ-015 SHALL scale by arithmetic right shift of SHIFT = 3*log2(DECIM) - 15 bits (6 at DECIM=128).
REQ-016 SHALL saturate the shifted value to [-32768, +32767]; full-scale +1 input yields 32767.
REQ-017 SHALL drive ce_out high for exactly one clk cycle per sample event, even if clk_enable drops while it is high.
REQ-018 SHALL hold output_data unchanged between ce_out strobes.
REQ-019 SHALL suppress ce_out and leave output_data at 0 for the first 3 sample events after reset (warm-up), via a 2-bit warm-up counter.
REQ-020 SHALL, with clk_enable held high, produce one ce_out every DECIM clk cycles after warm-up.

Reset
REQ-021 SHALL asynchronously clear integrators, combs, delay registers, decimation counter, warm-up counter, output_data (0) and ce_out (0) on reset.
REQ-022 SHALL, when reset asserts mid-frame or mid-pipeline, discard in-flight samples and restart warm-up from zero after release.

Configuration
REQ-023 SHALL, with macro PDM_IN_SYNC_EN defined, pass pdm_in through a two-flop synchronizer (reset to 0, clocked by clk, not gated by clk_enable) before mapping, adding 2 cycles input latency.
REQ-024 SHALL, without PDM_IN_SYNC_EN, sample pdm_in directly; pdm_in is then required to be synchronous to clk.

Structure
REQ-025 SHALL place CIC_ORDER (3), DECIM default, PCM_W (16), PCM_MAX/PCM_MIN limits and the ACC_W/SHIFT functions in shared package sd_dac_pkg.
REQ-026 SHALL implement one integrator stage as sub-module cic_integrator, instantiated three times; combs, counters and output stage stay in pdm_cic_decimator.

Verification
REQ-027 SHALL cover: pdm_in constant 1, DECIM=128 -> no ce_out for first 3 sample events, then output_data = 32767 on every strobe, strobes 128 cycles apart.
REQ-028 SHALL cover: pdm_in constant 0 -> output_data = -32768 on every strobe after warm-up.
REQ-029 SHALL cover: pdm_in alternating 1,0 -> output_data = 0 on every strobe after warm-up.
REQ-030 SHALL cover: pdm_in repeating 1,1,1,0 -> output_data = 16384 on every strobe after warm-up.
REQ-031 SHALL cover: constant 1 input, clk_enable low for 50 cycles mid-frame -> that strobe interval becomes 178 cycles, value stays 32767, ce_out width stays 1 cycle.
REQ-032 SHALL cover: reset pulsed mid-frame after warm-up -> output_data = 0 and ce_out = 0 immediately; next strobe only on the 4th sample event after release.

Source files
------------

// File: rtl/sd_dac_pkg.sv
// sd_dac_pkg: shared CIC/PCM constants and width helpers for the PDM decimator.
package sd_dac_pkg;
  localparam int CIC_ORDER = 3;
  localparam int DECIM_DEF = 128;
  localparam int PCM_W     = 16;
  localparam int PCM_MAX   = 32767;
  localparam int PCM_MIN   = -32768;

  function automatic int acc_w(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

  function automatic int shift_w(input int decim);
    return CIC_ORDER * $clog2(decim) - (PCM_W - 1);
  endfunction
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one wrapping CIC integrator stage, advancing on qualified cycles.
module cic_integrator #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (en) acc <= acc + din;
endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 3rd-order CIC decimator turning a 1-bit PDM stream into 16-bit PCM.
// Optional input synchronizer enabled by defining PDM_IN_SYNC_EN.
module pdm_cic_decimator
  import sd_dac_pkg::*;
#(
  parameter int DECIM = DECIM_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    pdm_in,
  output logic signed [PCM_W-1:0] output_data,
  output logic                    ce_out
);
  localparam int ACC_W = acc_w(DECIM);
  localparam int SHIFT = shift_w(DECIM);
  localparam int CNT_W = $clog2(DECIM);
  localparam int SH_W  = ACC_W - SHIFT;

  logic pdm_bit;
`ifdef PDM_IN_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], pdm_in};
  assign pdm_bit = sync[1];
`else
  assign pdm_bit = pdm_in;
`endif

  logic [ACC_W-1:0] x, i1, i2, i3;
  assign x = pdm_bit ? ACC_W'(1) : '1;

  cic_integrator #(.W(ACC_W)) u_int1 (.clk(clk), .reset(reset), .en(clk_enable), .din(x),  .acc(i1));
  cic_integrator #(.W(ACC_W)) u_int2 (.clk(clk), .reset(reset), .en(clk_enable), .din(i1), .acc(i2));
  cic_integrator #(.W(ACC_W)) u_int3 (.clk(clk), .reset(reset), .en(clk_enable), .din(i2), .acc(i3));

  logic [CNT_W-1:0] cnt;
  logic [1:0]       warm;
  logic             sample_ev, v1, v2;
  logic [ACC_W-1:0] samp, z1, z2, z3, c1, c2, c3, comb;
  logic signed [SH_W-1:0]  sh;
  logic signed [PCM_W-1:0] pcm;

  assign sample_ev = clk_enable && cnt == CNT_W'(DECIM - 1);
  assign c1 = samp - z1;
  assign c2 = c1 - z2;
  assign c3 = c2 - z3;
  assign sh = SH_W'($signed(comb) >>> SHIFT);

  always_comb
    pcm = sh > $signed(SH_W'(PCM_MAX)) ? PCM_W'(PCM_MAX) :
          sh < $signed(SH_W'(PCM_MIN)) ? PCM_W'(PCM_MIN) : sh[PCM_W-1:0];

  // ce_out self-clears every clk so the strobe stays one cycle even if clk_enable drops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt         <= '0;
      warm        <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      samp        <= '0;
      z1          <= '0;
      z2          <= '0;
      z3          <= '0;
      comb        <= '0;
      output_data <= '0;
      ce_out      <= 1'b0;
    end else begin
      ce_out <= 1'b0;
      if (clk_enable) begin
        cnt <= cnt + 1'b1;
        v1  <= sample_ev;
        v2  <= v1;
        if (sample_ev) samp <= i3;
        if (v1) begin
          z1   <= samp;
          z2   <= c1;
          z3   <= c2;
          comb <= c3;
        end
        if (v2 && warm == 2'd3) begin
          output_data <= pcm;
          ce_out      <= 1'b1;
        end else if (v2) warm <= warm + 1'b1;
      end
    end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed checks of warm-up, full-scale, zero/half-scale patterns,
// clock-enable stall and mid-frame reset for the PDM CIC decimator at DECIM=128.
module tb_pdm_cic_decimator;
  logic clk = 1'b0, reset = 1'b1, clk_enable = 1'b1, pdm_in = 1'b0;
  logic signed [15:0] output_data;
  logic ce_out;
  int vectors = 0, errs = 0, mode = 0, ph = 0, cyc = 0, t_last = 0, gap;

  pdm_cic_decimator #(.DECIM(128)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .pdm_in(pdm_in),
    .output_data(output_data), .ce_out(ce_out)
  );

  always #5 clk = ~clk;

  function automatic logic pat(input int m, input int p);
    return m == 0 ? 1'b1 : m == 1 ? 1'b0 : m == 2 ? (p % 2 == 0) : (p % 4 != 3);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    pdm_in = pat(mode, ph);
    ph++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // returns cycles since previous strobe (or release), -1 on timeout
  task automatic wait_strobe(output int g);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ce_out && n < 2000);
    g = ce_out ? cyc - t_last : -1;
    t_last = cyc;
  endtask

  task automatic restart(input int m);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_data", output_data, 0);
    chk("rst_ce", ce_out, 0);
    repeat (3) tick();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    mode = m;
    pdm_in = pat(m, 0);
    ph = 1;
    t_last = cyc;
  endtask

  initial begin
    restart(0);
    repeat (300) tick();
    chk("warmup_quiet", output_data, 0);
    wait_strobe(gap);
    chk("c1_first_gap", gap, 514);
    chk("c1_first_val", output_data, 32767);
    tick();
    chk("c1_ce_width", ce_out, 0);
    chk("c1_hold", output_data, 32767);
    wait_strobe(gap);
    chk("c1_gap", gap, 128);
    chk("c1_val", output_data, 32767);

    clk_enable = 1'b0;
    tick();
    chk("stall_ce_width", ce_out, 0);
    repeat (49) tick();
    clk_enable = 1'b1;
    wait_strobe(gap);
    chk("stall_gap", gap, 178);
    chk("stall_val", output_data, 32767);
    wait_strobe(gap);
    chk("post_stall_gap", gap, 128);

    repeat (40) tick();
    restart(0);
    wait_strobe(gap);
    chk("rst_mid_gap", gap, 514);
    chk("rst_mid_val", output_data, 32767);

    restart(1);
    wait_strobe(gap);
    chk("c0_first_gap", gap, 514);
    chk("c0_val1", output_data, -32768);
    wait_strobe(gap);
    chk("c0_gap", gap, 128);
    chk("c0_val2", output_data, -32768);

    restart(2);
    wait_strobe(gap);
    chk("alt_gap", gap, 514);
    chk("alt_val1", output_data, 0);
    wait_strobe(gap);
    chk("alt_val2", output_data, 0);

    restart(3);
    wait_strobe(gap);
    chk("p1110_gap", gap, 514);
    chk("p1110_val1", output_data, 16384);
    wait_strobe(gap);
    chk("p1110_val2", output_data, 16384);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
